// File: rtl/gau_gray_window.sv
`default_nettype none
// ============================================================================
// Module   : gau_gray_window
// Purpose  : RGB -> luma conversion followed by a 3x3 Gaussian blur
//            (1 2 1 / 2 4 2 / 1 2 1, /16) over line buffers. Emits the blurred
//            gray aligned with the RGB of the window-centre pixel; the one-pixel
//            image border is dropped.
// Revision : 1.0 - initial release
// ============================================================================
module gau_gray_window #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSOF,
  input  logic       iDVAL,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  output logic       oDVAL,
  output logic [7:0] oR,
  output logic [7:0] oG,
  output logic [7:0] oB,
  output logic [7:0] oGRAY
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // A SOF pixel is always taken and forces position (0,0); otherwise pixels
  // are taken only while a frame is in progress.
  logic          accept;
  logic [CW-1:0] pos_col;
  logic [RW-1:0] pos_row;
  logic          last_col;

  assign accept   = iDVAL && (iSOF || (state_q == S_ACTIVE));
  assign pos_col  = iSOF ? '0 : col_q;
  assign pos_row  = iSOF ? '0 : row_q;
  assign last_col = (pos_col == COL_LAST);

  // Luma (R + 2G + B) >> 2 in 10 bits
  logic [9:0] luma_sum;
  logic [7:0] gray_in;
  assign luma_sum = {2'b00, iR} + {1'b0, iG, 1'b0} + {2'b00, iB};
  assign gray_in  = 8'(luma_sum >> 2);

  // Line buffers: lb1 holds row r-1, lb2 row r-2, rgb_mem the RGB of row r-1
  logic [7:0]  lb1_mem [IMG_W];
  logic [7:0]  lb2_mem [IMG_W];
  logic [23:0] rgb_mem [IMG_W];
  logic [7:0]  lb1_rd, lb2_rd;
  logic [23:0] rgb_rd;

  assign lb1_rd = lb1_mem[pos_col];
  assign lb2_rd = lb2_mem[pos_col];
  assign rgb_rd = rgb_mem[pos_col];

  // Line-buffer writes; contents need no reset since output waits for row 2
  always_ff @(posedge iCLK) begin
    if (accept) begin
      lb1_mem[pos_col] <= gray_in;
      lb2_mem[pos_col] <= lb1_rd;
      rgb_mem[pos_col] <= {iR, iG, iB};
    end
  end

  // 3x3 window (index 0 = newest column) and 2-deep centre-row RGB shift
  logic [7:0]  win_t_q [3], win_t_d [3];
  logic [7:0]  win_m_q [3], win_m_d [3];
  logic [7:0]  win_b_q [3], win_b_d [3];
  logic [23:0] rgb0_q, rgb0_d, rgb1_q, rgb1_d;
  logic        vld1_q, vld1_d;

  // Next frame position / state and window shift on accepted pixels
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_t_d = win_t_q;
    win_m_d = win_m_q;
    win_b_d = win_b_q;
    rgb0_d  = rgb0_q;
    rgb1_d  = rgb1_q;
    vld1_d  = 1'b0;
    if (accept) begin
      if (last_col) begin
        col_d   = '0;
        row_d   = pos_row + 1'b1;
        state_d = (pos_row == ROW_LAST) ? S_DONE : S_ACTIVE;
      end else begin
        col_d   = pos_col + 1'b1;
        row_d   = pos_row;
        state_d = S_ACTIVE;
      end
      win_t_d = '{lb2_rd, win_t_q[0], win_t_q[1]};
      win_m_d = '{lb1_rd, win_m_q[0], win_m_q[1]};
      win_b_d = '{gray_in, win_b_q[0], win_b_q[1]};
      rgb0_d  = rgb_rd;
      rgb1_d  = rgb0_q;
      vld1_d  = (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
    end
  end

  // Weighted 3-tap row sum a + 2b + c
  function automatic logic [11:0] row3(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    return {4'b0000, a} + {3'b000, b, 1'b0} + {4'b0000, c};
  endfunction

  logic [11:0] blur_sum, blur_rnd;
  logic [7:0]  blur_gray;
  assign blur_sum  = row3(win_t_q[0], win_t_q[1], win_t_q[2])
                   + (row3(win_m_q[0], win_m_q[1], win_m_q[2]) << 1)
                   + row3(win_b_q[0], win_b_q[1], win_b_q[2]);
  assign blur_rnd  = blur_sum + 12'd8;
  assign blur_gray = 8'(blur_rnd >> 4);

  logic       out_dval_q, out_dval_d;
  logic [7:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
  logic [7:0] out_gray_q, out_gray_d;

  // Output register: load on a qualified window, otherwise hold
  always_comb begin
    out_dval_d = vld1_q;
    out_r_d    = out_r_q;
    out_g_d    = out_g_q;
    out_b_d    = out_b_q;
    out_gray_d = out_gray_q;
    if (vld1_q) begin
      {out_r_d, out_g_d, out_b_d} = rgb1_q;
      out_gray_d = blur_gray;
    end
  end

  // State, counters, window and output registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      win_t_q    <= '{default: '0};
      win_m_q    <= '{default: '0};
      win_b_q    <= '{default: '0};
      rgb0_q     <= '0;
      rgb1_q     <= '0;
      vld1_q     <= 1'b0;
      out_dval_q <= 1'b0;
      out_r_q    <= '0;
      out_g_q    <= '0;
      out_b_q    <= '0;
      out_gray_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      win_t_q    <= win_t_d;
      win_m_q    <= win_m_d;
      win_b_q    <= win_b_d;
      rgb0_q     <= rgb0_d;
      rgb1_q     <= rgb1_d;
      vld1_q     <= vld1_d;
      out_dval_q <= out_dval_d;
      out_r_q    <= out_r_d;
      out_g_q    <= out_g_d;
      out_b_q    <= out_b_d;
      out_gray_q <= out_gray_d;
    end
  end

  assign oDVAL = out_dval_q;
  assign oR    = out_r_q;
  assign oG    = out_g_q;
  assign oB    = out_b_q;
  assign oGRAY = out_gray_q;

endmodule
`default_nettype wire
